// File: rtl/piso_arbiter.sv
// -----------------------------------------------------------------------------
// piso_arbiter
//
// Round-robin arbiter and load sequencer in front of a single `piso`
// serializer. Picks one of N parallel requesters, captures its WIDTH-bit
// word, pulses the serializer load strobe and then counts out WIDTH shift
// cycles while flagging which requester owns the serial stream.
//
// Parameters
//   N      number of requesters (2..8)
//   WIDTH  word width, equal to the serializer data_in width
//   ID_W   owner index width, ceil(log2(N))
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   req[N]         per-requester request, held with stable data until ack
//   data_flat      requester i word at [i*WIDTH +: WIDTH]
//   ack[N]         one-hot single-cycle capture acknowledge
//   piso_data      word to the serializer data_in
//   piso_write_en  one-cycle serializer load pulse
//   busy           high in every state except IDLE
//   frame_valid    high while serial_out carries a bit of the current word
//   owner          index of the requester being serialized
//
// Build option
//   PISO_ARB_GAP_EN  inserts one GAP cycle between consecutive frames
//                    (frame period WIDTH+2 instead of WIDTH+1).
// -----------------------------------------------------------------------------
module piso_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] data_flat,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   piso_data,
    output logic               piso_write_en,
    output logic               busy,
    output logic               frame_valid,
    output logic [ID_W-1:0]    owner
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_ARB_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   ptr_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic              grant;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [WIDTH-1:0]  win_data;
    logic [ID_W:0]     cand;

    // Winner search: walk the requesters from rr_ptr upward with wrap at N.
    // Scanning the offsets from highest to lowest lets the nearest one win.
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N)) begin
                cand = cand - (ID_W+1)'(N);
            end
            if (req[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_data = data_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (win_idx == ID_W'(N - 1)) ? '0 : win_idx + ID_W'(1);

    // State register plus the registered datapath (ack, word, owner, pointer,
    // bit counter). An asserted reset abandons any frame in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            bit_cnt   <= '0;
            ack       <= '0;
            piso_data <= '0;
            owner     <= '0;
        end else begin
            state <= state_next;
            ack   <= '0;
            if (grant) begin
                ack[win_idx] <= 1'b1;
                piso_data    <= win_data;
                owner        <= win_idx;
                rr_ptr       <= ptr_next;
            end
            if (state == LOAD) begin
                bit_cnt <= CNT_W'(WIDTH - 1);
            end else if (state == SHIFT && bit_cnt != '0) begin
                bit_cnt <= bit_cnt - CNT_W'(1);
            end
        end
    end

    // Next state and grant. Arbitration happens in IDLE, in GAP, and (without
    // the gap option) on the last shift bit so the next load follows at once.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant      = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == '0) begin
`ifdef PISO_ARB_GAP_EN
                    state_next = GAP;
`else
                    if (win_found) begin
                        grant      = 1'b1;
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                    end
`endif
                end
            end
`ifdef PISO_ARB_GAP_EN
            GAP: begin
                if (win_found) begin
                    grant      = 1'b1;
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register only, so they fall
    // together with an asynchronous reset and never depend on req.
    always_comb begin
        piso_write_en = (state == LOAD);
        busy          = (state != IDLE);
        frame_valid   = (state == SHIFT);
    end

endmodule

// File: tb/tb_piso_arbiter.sv
// -----------------------------------------------------------------------------
// tb_piso_arbiter
//
// Self-checking bench for piso_arbiter: a table of single-grant vectors,
// hand-written sequences for reset, round-robin order, back-to-back spacing,
// mid-frame reset and late request drop, then a randomized run compared
// against a transaction-level schedule model. Honours PISO_ARB_GAP_EN.
// -----------------------------------------------------------------------------
module tb_piso_arbiter;

    localparam int N      = 4;
    localparam int WIDTH  = 4;
    localparam int ID_W   = 2;
    localparam int N_RAND = 400;
    localparam int MAXC   = N_RAND + 32;
`ifdef PISO_ARB_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic               clk;
    logic               reset;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] data_flat;
    logic [N-1:0]       ack;
    logic [WIDTH-1:0]   piso_data;
    logic               piso_write_en;
    logic               busy;
    logic               frame_valid;
    logic [ID_W-1:0]    owner;

    piso_arbiter #(.N(N), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .data_flat     (data_flat),
        .ack           (ack),
        .piso_data     (piso_data),
        .piso_write_en (piso_write_en),
        .busy          (busy),
        .frame_valid   (frame_valid),
        .owner         (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    // Behavioural MSB-first serializer standing in for the piso instance.
    logic [WIDTH-1:0] sh;
    logic             serial_out;
    always @(posedge clk or negedge reset) begin
        if (!reset)              sh <= '0;
        else if (piso_write_en)  sh <= piso_data;
        else                     sh <= sh << 1;
    end
    assign serial_out = sh[WIDTH-1];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output logic [N-1:0] a, output logic ok);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                a  = ack;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        @(posedge clk); #1;
        reset = 1'b0;
        req   = r;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Round-robin choice computed straight from the rule: first requester at
    // or after ptr, modulo N.
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0]       req;
        logic [N*WIDTH-1:0] data;
        logic [N-1:0]       exp_ack;
        logic [ID_W-1:0]    exp_owner;
        logic [WIDTH-1:0]   exp_data;
    } vec_t;

    vec_t tbl[7];

    // Randomized-run schedule of expected outputs, indexed by cycle.
    logic [N-1:0]     e_ack [MAXC];
    bit               e_we  [MAXC];
    bit               e_fv  [MAXC];
    bit               e_busy[MAXC];
    logic [ID_W-1:0]  g_own [MAXC];
    logic [WIDTH-1:0] g_dat [MAXC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]     a;
        logic             ok;
        logic [WIDTH-1:0] bits;
        int               fv_cnt;
        int               extra_we;
        int               we_cyc[4];
        logic [N-1:0]     rr_ack[4];
        logic [ID_W-1:0]  rr_own[4];
        logic             seen_ack;
        logic             seen_we;
        int               m_ptr;
        int               m_arb_at;
        int               w;
        logic [ID_W-1:0]  cur_own;
        logic [WIDTH-1:0] cur_dat;
        logic [N-1:0]     ack_seen;

        // Pointer evolves 1 -> 3 -> 0 -> 1 -> 2 -> 1 -> 2 -> 1 across entries.
        tbl[0] = '{4'b0100, 16'h793C, 4'b0100, 2'd2, 4'b1001};
        tbl[1] = '{4'b1011, 16'h793C, 4'b1000, 2'd3, 4'h7};
        tbl[2] = '{4'b1011, 16'h5A6E, 4'b0001, 2'd0, 4'hE};
        tbl[3] = '{4'b1011, 16'h5A6E, 4'b0010, 2'd1, 4'h6};
        tbl[4] = '{4'b0001, 16'h1234, 4'b0001, 2'd0, 4'h4};
        tbl[5] = '{4'b1111, 16'hF0A5, 4'b0010, 2'd1, 4'hA};
        tbl[6] = '{4'b0011, 16'h8421, 4'b0001, 2'd0, 4'h1};

        rr_ack[0] = 4'b0001; rr_own[0] = 2'd0;
        rr_ack[1] = 4'b0010; rr_own[1] = 2'd1;
        rr_ack[2] = 4'b1000; rr_own[2] = 2'd3;
        rr_ack[3] = 4'b0001; rr_own[3] = 2'd0;

        // ---------------- reset held with all requests high ----------------
        reset     = 1'b0;
        req       = '1;
        data_flat = 16'h793C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs",
                  {ack, piso_write_en, frame_valid, busy, owner, piso_data}, 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        wait_ack(a, ok);
        check("reset_first_ack_seen", ok, 1);
        check("reset_first_ack", a, 4'b0001);
        check("reset_first_owner", owner, 0);
        @(posedge clk); #1;
        req = '0;
        wait_idle(ok);
        check("reset_frame_idle", ok, 1);

        // ---------------- table of single grants ----------------
        for (int t = 0; t < 7; t++) begin
            @(posedge clk); #1;
            req       = tbl[t].req;
            data_flat = tbl[t].data;
            wait_ack(a, ok);
            check($sformatf("tbl%0d_ack_seen", t), ok, 1);
            check($sformatf("tbl%0d_ack", t), a, tbl[t].exp_ack);
            check($sformatf("tbl%0d_owner", t), owner, tbl[t].exp_owner);
            check($sformatf("tbl%0d_load", t), {piso_write_en, piso_data},
                  {1'b1, tbl[t].exp_data});
            @(posedge clk); #1;
            req = '0;
            fv_cnt   = 0;
            extra_we = 0;
            bits     = '0;
            ok       = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!busy) begin
                    ok = 1'b1;
                    break;
                end
                if (frame_valid) begin
                    fv_cnt++;
                    bits = {bits[WIDTH-2:0], serial_out};
                end
                if (piso_write_en) extra_we++;
            end
            check($sformatf("tbl%0d_idle", t), ok, 1);
            check($sformatf("tbl%0d_fv_cycles", t), fv_cnt, WIDTH);
            check($sformatf("tbl%0d_serial", t), bits, tbl[t].exp_data);
            check($sformatf("tbl%0d_extra_load", t), extra_we, 0);
        end

        // ---------------- round-robin with requests held ----------------
        data_flat = 16'h793C;
        do_reset(4'b1011);
        for (int i = 0; i < 4; i++) begin
            wait_ack(a, ok);
            we_cyc[i] = cyc_cnt;
            check($sformatf("rr%0d_ack_seen", i), ok, 1);
            check($sformatf("rr%0d_ack", i), a, rr_ack[i]);
            check($sformatf("rr%0d_owner", i), owner, rr_own[i]);
            check($sformatf("rr%0d_write_en", i), piso_write_en, 1);
            if (i > 0) begin
                check($sformatf("rr%0d_load_spacing", i),
                      we_cyc[i] - we_cyc[i-1], WIDTH + 1 + GAP);
            end
        end
        @(posedge clk); #1;
        req = '0;
        wait_idle(ok);
        check("rr_idle", ok, 1);

        // ---------------- reset during the second shift cycle ----------------
        do_reset('0);
        req       = 4'b0100;
        data_flat = 16'h793C;
        wait_ack(a, ok);
        check("mid_ack", a, 4'b0100);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("mid_pre_fv", {frame_valid, busy}, 2'b11);
        #1;
        reset = 1'b0;
        #1;
        check("mid_async_drop",
              {ack, piso_write_en, frame_valid, busy, owner, piso_data}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        req   = 4'b1100;
        wait_ack(a, ok);
        check("mid_restart_ack", a, 4'b0100);
        check("mid_restart_owner", owner, 2);

        // ---------------- late one-cycle request during SHIFT ----------------
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #1;
        req = 4'b0010;
        @(posedge clk); #1;
        req = '0;
        seen_ack = 1'b0;
        seen_we  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack != '0)    seen_ack = 1'b1;
            if (piso_write_en) seen_we = 1'b1;
        end
        check("late_drop_ack", seen_ack, 0);
        check("late_drop_load", seen_we, 0);

        // ---------------- randomized run against schedule model ----------------
        for (int c = 0; c < MAXC; c++) begin
            e_ack[c]  = '0;
            e_we[c]   = 1'b0;
            e_fv[c]   = 1'b0;
            e_busy[c] = 1'b0;
            g_own[c]  = '0;
            g_dat[c]  = '0;
        end
        m_ptr    = 0;
        m_arb_at = 0;
        cur_own  = '0;
        cur_dat  = '0;
        ack_seen = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        req   = '0;
        @(negedge clk);
        @(posedge clk); #1;
        reset     = 1'b1;
        data_flat = 16'($urandom);
        req       = N'($urandom);
        for (int c = 0; c < N_RAND; c++) begin
            @(negedge clk);
            if (e_ack[c] != '0) begin
                cur_own = g_own[c];
                cur_dat = g_dat[c];
            end
            check($sformatf("rand_c%0d", c),
                  {ack, piso_write_en, frame_valid, busy, owner, piso_data},
                  {e_ack[c], e_we[c], e_fv[c], e_busy[c], cur_own, cur_dat});
            if (c >= m_arb_at) begin
                w = rr_pick(req, m_ptr);
                if (w >= 0) begin
                    m_ptr = (w + 1) % N;
                    e_ack[c+1]    = '0;
                    e_ack[c+1][w] = 1'b1;
                    e_we[c+1]     = 1'b1;
                    g_own[c+1]    = ID_W'(w);
                    g_dat[c+1]    = data_flat[w*WIDTH +: WIDTH];
                    for (int t = c + 1; t <= c + 1 + WIDTH + GAP; t++) e_busy[t] = 1'b1;
                    for (int t = c + 2; t <= c + 1 + WIDTH; t++)       e_fv[t]   = 1'b1;
                    m_arb_at = c + 1 + WIDTH + GAP;
                end else begin
                    m_arb_at = c + 1;
                end
            end
            ack_seen = ack;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (ack_seen[i] || $urandom_range(0, 39) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    data_flat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
